// File: rtl/dlx_hazard_ctrl.sv
// Pipeline sequencer for the DLX 5-stage core: load-use interlock, redirect flush,
// data-memory wait freeze with timeout detection, and saturating perf counters.
module dlx_hazard_ctrl #(
    parameter int LU_BUBBLES  = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_ID,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic             valid_EX,
    input  logic [4:0]       Rd_EX,
    input  logic             d_load_enable_EX,
    input  logic             redirect_EX,
    input  logic             d_req_MEM,
    input  logic             d_ready_MEM,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             bubble_EX,
    output logic             flush_ID,
    output logic             freeze,
    output logic             mem_timeout_err,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    localparam logic [2:0]  LU_INIT = 3'(LU_BUBBLES - 1);
    localparam logic [15:0] TO_MAX  = 16'(MEM_TIMEOUT);
    localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      ret_state;
    state_t      eff_state;
    logic [2:0]  lu_cnt;
    logic [15:0] wait_cnt;
    logic        haz;
    logic        mwait;

    assign ctrl_state = state;

    always_comb begin
        haz = valid_ID && valid_EX && d_load_enable_EX && (Rd_EX != 5'd0) &&
              ((use_rs1_ID && (Rs1_ID == Rd_EX)) || (use_rs2_ID && (Rs2_ID == Rd_EX)));
        mwait = d_req_MEM && !d_ready_MEM;
        // While leaving MEM_WAIT the cycle behaves as the state that was frozen.
        eff_state = (state == MEM_WAIT) ? ret_state : state;

        // NOTE: every output gets a default first so no path can infer a latch.
        stall_IF  = 1'b0;
        stall_ID  = 1'b0;
        bubble_EX = 1'b0;
        flush_ID  = 1'b0;
        freeze    = 1'b0;
        if (reset_n) begin
            if (mwait) begin
                freeze   = 1'b1;
                stall_IF = 1'b1;
                stall_ID = 1'b1;
            end else if (redirect_EX) begin
                flush_ID  = 1'b1;
                bubble_EX = 1'b1;
            end else if (eff_state == LU_STALL || haz) begin
                stall_IF  = 1'b1;
                stall_ID  = 1'b1;
                bubble_EX = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= RUN;
            ret_state       <= RUN;
            lu_cnt          <= '0;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
            perf_stall      <= '0;
            perf_flush      <= '0;
        end else begin
            if (stall_IF && perf_stall != '1)
                perf_stall <= perf_stall + 1'b1;

            if (mwait) begin
                state     <= MEM_WAIT;
                ret_state <= eff_state;
                if (wait_cnt != TO_MAX)
                    wait_cnt <= wait_cnt + 16'd1;
                if (wait_cnt >= TO_LAST)
                    mem_timeout_err <= 1'b1;
            end else begin
                wait_cnt <= '0;
                if (redirect_EX) begin
                    state  <= RUN;
                    lu_cnt <= '0;
                    if (perf_flush != '1)
                        perf_flush <= perf_flush + 1'b1;
                end else if (eff_state == LU_STALL) begin
                    if (lu_cnt <= 3'd1) begin
                        state  <= RUN;
                        lu_cnt <= '0;
                    end else begin
                        state  <= LU_STALL;
                        lu_cnt <= lu_cnt - 3'd1;
                    end
                end else if (haz && LU_BUBBLES > 1) begin
                    state  <= LU_STALL;
                    lu_cnt <= LU_INIT;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_dlx_hazard_ctrl.sv
// Directed bench for dlx_hazard_ctrl: load-use, redirect, freeze and timeout sequences
// with hand-computed expectations (LU_BUBBLES=2, MEM_TIMEOUT=4).
module tb_dlx_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_ID, use_rs1_ID, use_rs2_ID, valid_EX, d_load_enable_EX;
    logic [4:0]  Rs1_ID, Rs2_ID, Rd_EX;
    logic        redirect_EX, d_req_MEM, d_ready_MEM;
    logic        stall_IF, stall_ID, bubble_EX, flush_ID, freeze, mem_timeout_err;
    logic [1:0]  ctrl_state;
    logic [15:0] perf_stall, perf_flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dlx_hazard_ctrl #(.LU_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_ID(valid_ID), .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
        .valid_EX(valid_EX), .Rd_EX(Rd_EX), .d_load_enable_EX(d_load_enable_EX),
        .redirect_EX(redirect_EX), .d_req_MEM(d_req_MEM), .d_ready_MEM(d_ready_MEM),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
        .flush_ID(flush_ID), .freeze(freeze), .mem_timeout_err(mem_timeout_err),
        .ctrl_state(ctrl_state), .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then move 1 time unit past it before driving.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle well away from the edge.
    task automatic settle();
        #2;
    endtask

    task automatic idle();
        valid_ID = 0; use_rs1_ID = 0; use_rs2_ID = 0; Rs1_ID = 0; Rs2_ID = 0;
        valid_EX = 0; Rd_EX = 0; d_load_enable_EX = 0;
        redirect_EX = 0; d_req_MEM = 0; d_ready_MEM = 0;
    endtask

    task automatic load_use(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                            input logic u2, input logic [4:0] rd, input logic ld);
        valid_ID = 1; Rs1_ID = rs1; use_rs1_ID = u1; Rs2_ID = rs2; use_rs2_ID = u2;
        valid_EX = 1; Rd_EX = rd; d_load_enable_EX = ld;
    endtask

    initial begin
        idle();
        reset_n = 0;
        cyc(); cyc();
        // Outputs must stay quiet in reset even with every trigger present.
        load_use(5'd3, 1, 5'd0, 0, 5'd3, 1);
        d_req_MEM = 1; redirect_EX = 1; settle();
        check("rst_stall", {31'd0, stall_IF}, 0);
        check("rst_freeze", {31'd0, freeze}, 0);
        check("rst_flush", {31'd0, flush_ID}, 0);
        cyc();
        idle(); reset_n = 1; settle();
        check("rst_state", {30'd0, ctrl_state}, 0);
        check("rst_pstall", {16'd0, perf_stall}, 0);
        check("rst_pflush", {16'd0, perf_flush}, 0);
        check("rst_err", {31'd0, mem_timeout_err}, 0);

        // LW r3 in EX, ADD reads r3 in ID: two bubbles, states 00,01,00.
        load_use(5'd3, 1, 5'd0, 0, 5'd3, 1); settle();
        check("lu1_stall", {31'd0, stall_IF}, 1);
        check("lu1_bubble", {31'd0, bubble_EX}, 1);
        check("lu1_stallid", {31'd0, stall_ID}, 1);
        check("lu1_state", {30'd0, ctrl_state}, 0);
        cyc(); valid_EX = 0; settle();
        check("lu2_stall", {31'd0, stall_IF}, 1);
        check("lu2_bubble", {31'd0, bubble_EX}, 1);
        check("lu2_state", {30'd0, ctrl_state}, 1);
        cyc(); idle(); settle();
        check("lu3_stall", {31'd0, stall_IF}, 0);
        check("lu3_state", {30'd0, ctrl_state}, 0);
        check("lu_pstall", {16'd0, perf_stall}, 2);

        // Non-hazards: Rd_EX=0, unused rs1, store.
        load_use(5'd0, 1, 5'd0, 0, 5'd0, 1); settle();
        check("rd0_stall", {31'd0, stall_IF}, 0);
        load_use(5'd3, 0, 5'd0, 0, 5'd3, 1); settle();
        check("nouse_stall", {31'd0, stall_IF}, 0);
        load_use(5'd3, 1, 5'd0, 0, 5'd3, 0); settle();
        check("store_stall", {31'd0, stall_IF}, 0);
        cyc(); idle(); settle();
        check("nohaz_pstall", {16'd0, perf_stall}, 2);
        check("nohaz_state", {30'd0, ctrl_state}, 0);

        // Hazard through rs2.
        load_use(5'd1, 1, 5'd7, 1, 5'd7, 1); settle();
        check("rs2_stall", {31'd0, stall_IF}, 1);
        cyc(); valid_EX = 0; settle();
        check("rs2_state", {30'd0, ctrl_state}, 1);
        cyc(); idle(); settle();
        check("rs2_done", {30'd0, ctrl_state}, 0);
        check("rs2_pstall", {16'd0, perf_stall}, 4);

        // Redirect pulse in RUN.
        redirect_EX = 1; settle();
        check("rd_flush", {31'd0, flush_ID}, 1);
        check("rd_bubble", {31'd0, bubble_EX}, 1);
        check("rd_stall", {31'd0, stall_IF}, 0);
        cyc(); idle(); settle();
        check("rd_flush_off", {31'd0, flush_ID}, 0);
        check("rd_bubble_off", {31'd0, bubble_EX}, 0);
        check("rd_pflush", {16'd0, perf_flush}, 1);

        // Hazard and redirect together: flush wins, no LU_STALL.
        load_use(5'd3, 1, 5'd0, 0, 5'd3, 1); redirect_EX = 1; settle();
        check("hr_flush", {31'd0, flush_ID}, 1);
        check("hr_stall", {31'd0, stall_IF}, 0);
        cyc(); idle(); settle();
        check("hr_state", {30'd0, ctrl_state}, 0);
        check("hr_pflush", {16'd0, perf_flush}, 2);
        check("hr_pstall", {16'd0, perf_stall}, 4);

        // Freeze for 3 cycles inside LU_STALL with lu_cnt=1, then the last bubble.
        load_use(5'd3, 1, 5'd0, 0, 5'd3, 1); settle();
        cyc(); idle(); settle();
        check("fz_lustate", {30'd0, ctrl_state}, 1);
        d_req_MEM = 1; d_ready_MEM = 0; settle();
        check("fz1_freeze", {31'd0, freeze}, 1);
        check("fz1_bubble", {31'd0, bubble_EX}, 0);
        cyc(); settle();
        check("fz2_state", {30'd0, ctrl_state}, 2);
        check("fz2_freeze", {31'd0, freeze}, 1);
        cyc(); settle();
        check("fz3_freeze", {31'd0, freeze}, 1);
        cyc(); d_ready_MEM = 1; settle();
        check("fzx_freeze", {31'd0, freeze}, 0);
        check("fzx_bubble", {31'd0, bubble_EX}, 1);
        check("fzx_stall", {31'd0, stall_IF}, 1);
        cyc(); idle(); settle();
        check("fz_state", {30'd0, ctrl_state}, 0);
        check("fz_bubble_off", {31'd0, bubble_EX}, 0);
        check("fz_pstall", {16'd0, perf_stall}, 9);
        check("fz_err", {31'd0, mem_timeout_err}, 0);

        // Timeout: 6 wait cycles, error after the 4th; redirect ignored while frozen.
        d_req_MEM = 1; d_ready_MEM = 0; redirect_EX = 1; settle();
        check("to_rd_ign", {31'd0, flush_ID}, 0);
        cyc(); redirect_EX = 0;
        cyc(); cyc(); settle();
        check("to_err_pre", {31'd0, mem_timeout_err}, 0);
        cyc(); settle();
        check("to_err_set", {31'd0, mem_timeout_err}, 1);
        cyc(); cyc(); idle(); settle();
        check("to_freeze_off", {31'd0, freeze}, 0);
        cyc(); settle();
        check("to_err_hold", {31'd0, mem_timeout_err}, 1);
        check("to_state", {30'd0, ctrl_state}, 0);
        check("to_pflush", {16'd0, perf_flush}, 2);
        check("to_pstall", {16'd0, perf_stall}, 15);

        // Reset clears the sticky error and counters.
        reset_n = 0; d_req_MEM = 1; settle();
        check("rst2_freeze", {31'd0, freeze}, 0);
        cyc(); idle(); reset_n = 1; settle();
        check("rst2_err", {31'd0, mem_timeout_err}, 0);
        check("rst2_pstall", {16'd0, perf_stall}, 0);
        check("rst2_pflush", {16'd0, perf_flush}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
